// File: rtl/decrypt_result_buffer_pkg.sv
// Shared definitions for the decryption result buffer: FSM state encoding and the
// default address/data widths that must match the Decryption instance.
package decrypt_result_buffer_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/decrypt_result_buffer_result_store.sv
// Result storage: MEM_DEPTH x DATA_WIDTH register file with synchronous write,
// asynchronous read and a per-slot valid vector that can be cleared in one cycle.
module result_store #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [MEM_DEPTH-1:0]  valid
);

  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];
  logic [MEM_DEPTH-1:0]  valid_r;

  // Data array write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Valid bits: reset and bulk clear dominate a same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {MEM_DEPTH{1'b0}};
    end else if (clr) begin
      valid_r <= {MEM_DEPTH{1'b0}};
    end else if (we) begin
      valid_r[waddr] <= 1'b1;
    end
  end

  assign rdata = mem_r[raddr];
  assign valid = valid_r;

endmodule

// File: rtl/decrypt_result_buffer.sv
// Capture stage behind the Decryption RAM port: absorbs random-order writes, then drains
// written slots in ascending order on the finished edge. Option: DUP_WRITE_CHECK_EN adds dup_err.
module decrypt_result_buffer
  import decrypt_result_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  wr_ena,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  finished_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  drain_done,
  output logic                  late_err
`ifdef DUP_WRITE_CHECK_EN
  ,
  output logic                  dup_err
`endif
);

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  state_e                state_r, state_s;
  logic [ADDR_WIDTH-1:0] ptr_r, ptr_s;
  logic [ADDR_WIDTH:0]   count_r, count_s;
  logic                  fin_q_r;
  logic                  done_r;
  logic                  late_r, late_s;
  logic                  clr_s;
  logic                  in_range_s;
  logic                  wr_hit_s;
  logic [ADDR_WIDTH-1:0] wr_idx_s;
  logic                  slot_valid_s;
  logic                  cur_valid_s;
  logic [MEM_DEPTH-1:0]  valid_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  out_valid_s;
  logic [ADDR_WIDTH-1:0] out_addr_s;
  logic [DATA_WIDTH-1:0] out_data_s;

  result_store #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_store (
    .clk   (clk),
    .rst   (rst),
    .we    (ena & wr_hit_s),
    .waddr (wr_idx_s),
    .wdata (wr_data),
    .clr   (ena & clr_s),
    .raddr (ptr_r),
    .rdata (rd_data_s),
    .valid (valid_s)
  );

  // Write qualification; out-of-range addresses are steered to slot 0 but never enabled
  always_comb begin
    in_range_s   = ({1'b0, wr_addr} < DEPTH_W);
    wr_idx_s     = in_range_s ? wr_addr : {ADDR_WIDTH{1'b0}};
    wr_hit_s     = wr_ena & in_range_s & (state_r == CAPTURE);
    slot_valid_s = valid_s[wr_idx_s];
    cur_valid_s  = valid_s[ptr_r];
  end

  // Next-state and stream decode
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    count_s     = count_r;
    clr_s       = 1'b0;
    late_s      = late_r | (wr_ena & (state_r != CAPTURE));
    out_valid_s = 1'b0;
    out_addr_s  = {ADDR_WIDTH{1'b0}};
    out_data_s  = {DATA_WIDTH{1'b0}};
    case (state_r)
      CAPTURE: begin
        if (wr_hit_s && !slot_valid_s) begin
          count_s = count_r + CNT_ONE;
        end else begin
          count_s = count_r;
        end
        if (finished_in && !fin_q_r) begin
          state_s = DRAIN;
          ptr_s   = {ADDR_WIDTH{1'b0}};
        end else begin
          state_s = CAPTURE;
        end
      end
      DRAIN: begin
        out_valid_s = cur_valid_s;
        out_addr_s  = ptr_r;
        out_data_s  = rd_data_s;
        // Empty slots are skipped at one per cycle; filled slots wait for the consumer
        if (!cur_valid_s || out_ready) begin
          if (ptr_r == PTR_LAST) begin
            state_s = DONE;
          end else begin
            ptr_s = ptr_r + PTR_ONE;
          end
        end else begin
          ptr_s = ptr_r;
        end
      end
      DONE: begin
        if (!finished_in) begin
          clr_s   = 1'b1;
          count_s = {(ADDR_WIDTH + 1){1'b0}};
          ptr_s   = {ADDR_WIDTH{1'b0}};
          state_s = CAPTURE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = CAPTURE;
      end
    endcase
  end

  // Control registers; ena low freezes everything except reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CAPTURE;
      ptr_r   <= {ADDR_WIDTH{1'b0}};
      count_r <= {(ADDR_WIDTH + 1){1'b0}};
      fin_q_r <= 1'b0;
      done_r  <= 1'b0;
      late_r  <= 1'b0;
    end else if (ena) begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      count_r <= count_s;
      fin_q_r <= finished_in;
      done_r  <= (state_s == DONE);
      late_r  <= late_s;
    end
  end

`ifdef DUP_WRITE_CHECK_EN
  logic dup_r;

  // Sticky flag for a capture-phase rewrite of an already-valid slot
  always_ff @(posedge clk) begin
    if (rst) begin
      dup_r <= 1'b0;
    end else if (ena) begin
      dup_r <= dup_r | (wr_hit_s & slot_valid_s);
    end
  end

  assign dup_err = dup_r;
`endif

  assign out_valid  = out_valid_s;
  assign out_addr   = out_addr_s;
  assign out_data   = out_data_s;
  assign count      = count_r;
  assign drain_done = done_r;
  assign late_err   = late_r;

endmodule

// File: tb/tb_decrypt_result_buffer.sv
// Directed bench for decrypt_result_buffer: table-driven capture/drain vectors plus
// hand-written stall, late-write, reset-abort and enable-freeze sequences.
module tb_decrypt_result_buffer;

  logic       clk = 1'b0;
  logic       rst, ena, wr_ena, finished_in, out_ready;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       out_valid;
  logic [3:0] out_addr;
  logic [7:0] out_data;
  logic [4:0] count;
  logic       drain_done, late_err;
`ifdef DUP_WRITE_CHECK_EN
  logic       dup_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] got_a [16];
  logic [7:0] got_d [16];

  typedef struct packed {
    logic [2:0]      nw;
    logic [3:0][3:0] wa;
    logic [3:0][7:0] wd;
    logic [4:0]      cnt;
    logic [2:0]      nb;
    logic [3:0][3:0] ba;
    logic [3:0][7:0] bd;
    logic            dup;
  } vec_t;

  vec_t vecs [4];

  decrypt_result_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .wr_ena      (wr_ena),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .finished_in (finished_in),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .count       (count),
    .drain_done  (drain_done),
    .late_err    (late_err)
`ifdef DUP_WRITE_CHECK_EN
    ,
    .dup_err     (dup_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b1; wr_ena = 1'b0; wr_addr = 4'h0; wr_data = 8'h00;
    finished_in = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_ena = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_ena = 1'b0;
  endtask

  task automatic load_case1();
    wr(4'h0, 8'h11); wr(4'h1, 8'h22); wr(4'h2, 8'h33); wr(4'h3, 8'h44);
  endtask

  // Raise finished_in and collect beats; done_cyc counts clock edges from the rise
  task automatic drain(input int stall_beat, input int stall_len, input int late_cyc,
                       output int nb, output int done_cyc);
    int cyc;
    int stall_left;
    logic [3:0] hold_a;
    logic [7:0] hold_d;
    nb = 0; done_cyc = 0; cyc = 0; stall_left = stall_len;
    hold_a = 4'h0; hold_d = 8'h00;
    finished_in = 1'b1; out_ready = 1'b1;
    while (cyc < 200 && done_cyc == 0) begin
      step();
      cyc++;
      wr_ena = (cyc == late_cyc); wr_addr = 4'h7; wr_data = 8'h77;
      if (drain_done) begin
        done_cyc = cyc;
        chk("done_out_valid", out_valid, 1'b0);
      end else if (out_valid && nb == stall_beat && stall_left > 0) begin
        out_ready = 1'b0;
        if (stall_left < stall_len) begin
          chk("stall_addr", out_addr, hold_a);
          chk("stall_data", out_data, hold_d);
        end else begin
          hold_a = out_addr; hold_d = out_data;
        end
        stall_left--;
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          if (nb < 16) begin
            got_a[nb] = out_addr; got_d[nb] = out_data;
          end
          nb++;
        end
      end
    end
    wr_ena = 1'b0;
  endtask

  task automatic chk_case1_beats(input string tag, input int nb);
    chk({tag, "_nbeats"}, nb, 4);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("%s_beat%0d_addr", tag, b), got_a[b], b);
      chk($sformatf("%s_beat%0d_data", tag, b), got_d[b], (b + 1) * 8'h11);
    end
  endtask

  initial begin
    int nb, dc;
    vecs[0] = '{nw:3'd4, wa:{4'h3, 4'h2, 4'h1, 4'h0}, wd:{8'h44, 8'h33, 8'h22, 8'h11},
                cnt:5'd4, nb:3'd4, ba:{4'h3, 4'h2, 4'h1, 4'h0}, bd:{8'h44, 8'h33, 8'h22, 8'h11},
                dup:1'b0};
    vecs[1] = '{nw:3'd2, wa:{4'h0, 4'h0, 4'h9, 4'h5}, wd:{8'h00, 8'h00, 8'h5A, 8'hA5},
                cnt:5'd2, nb:3'd2, ba:{4'h0, 4'h0, 4'h9, 4'h5}, bd:{8'h00, 8'h00, 8'h5A, 8'hA5},
                dup:1'b0};
    vecs[2] = '{nw:3'd2, wa:{4'h0, 4'h0, 4'h0, 4'hF}, wd:{8'h00, 8'h00, 8'h01, 8'hEE},
                cnt:5'd2, nb:3'd2, ba:{4'h0, 4'h0, 4'hF, 4'h0}, bd:{8'h00, 8'h00, 8'hEE, 8'h01},
                dup:1'b0};
    vecs[3] = '{nw:3'd2, wa:{4'h0, 4'h0, 4'h3, 4'h3}, wd:{8'h00, 8'h00, 8'h20, 8'h10},
                cnt:5'd1, nb:3'd1, ba:{4'h0, 4'h0, 4'h0, 4'h3}, bd:{8'h00, 8'h00, 8'h00, 8'h20},
                dup:1'b1};

    do_reset();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_addr", out_addr, 4'h0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_count", count, 5'd0);
    chk("rst_drain_done", drain_done, 1'b0);
    chk("rst_late_err", late_err, 1'b0);

    // Table: capture pattern, drain with ready held high
    for (int i = 0; i < 4; i++) begin
      do_reset();
      for (int w = 0; w < int'(vecs[i].nw); w++) begin
        wr(vecs[i].wa[w], vecs[i].wd[w]);
      end
      chk($sformatf("v%0d_count", i), count, vecs[i].cnt);
      drain(99, 0, 0, nb, dc);
      chk($sformatf("v%0d_nbeats", i), nb, vecs[i].nb);
      for (int b = 0; b < int'(vecs[i].nb); b++) begin
        chk($sformatf("v%0d_beat%0d_addr", i, b), got_a[b], vecs[i].ba[b]);
        chk($sformatf("v%0d_beat%0d_data", i, b), got_d[b], vecs[i].bd[b]);
      end
      chk($sformatf("v%0d_done_cyc", i), dc, 17);
      chk($sformatf("v%0d_late_err", i), late_err, 1'b0);
`ifdef DUP_WRITE_CHECK_EN
      chk($sformatf("v%0d_dup_err", i), dup_err, vecs[i].dup);
`endif
    end

    // Consumer stalls three cycles on beat (2,33)
    do_reset();
    load_case1();
    drain(2, 3, 0, nb, dc);
    chk_case1_beats("stall", nb);
    chk("stall_done_cyc", dc, 20);

    // Late write during DRAIN, then release finished_in in DONE
    do_reset();
    load_case1();
    drain(99, 0, 3, nb, dc);
    chk_case1_beats("late", nb);
    chk("late_done_cyc", dc, 17);
    chk("late_err_set", late_err, 1'b1);
    finished_in = 1'b0;
    step();
    chk("release_count", count, 5'd0);
    chk("release_drain_done", drain_done, 1'b0);
    chk("release_late_err", late_err, 1'b1);
    drain(99, 0, 0, nb, dc);
    chk("release_nbeats", nb, 0);
    chk("release_done_cyc", dc, 17);
    chk("release_late_err2", late_err, 1'b1);

    // Reset after the first beat aborts the drain
    do_reset();
    load_case1();
    finished_in = 1'b1; out_ready = 1'b1;
    step();
    step();
    chk("abort_pre_addr", out_addr, 4'h1);
    rst = 1'b1; finished_in = 1'b0;
    step();
    rst = 1'b0;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_out_addr", out_addr, 4'h0);
    chk("abort_out_data", out_data, 8'h00);
    chk("abort_count", count, 5'd0);
    chk("abort_drain_done", drain_done, 1'b0);
    drain(99, 0, 0, nb, dc);
    chk("abort_nbeats", nb, 0);
    chk("abort_done_cyc", dc, 17);

    // ena low during a stall freezes the presented slot
    do_reset();
    load_case1();
    finished_in = 1'b1; out_ready = 1'b0;
    step();
    step();
    chk("freeze_pre_addr", out_addr, 4'h0);
    chk("freeze_pre_data", out_data, 8'h11);
    ena = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("freeze%0d_valid", k), out_valid, 1'b1);
      chk($sformatf("freeze%0d_addr", k), out_addr, 4'h0);
      chk($sformatf("freeze%0d_data", k), out_data, 8'h11);
      chk($sformatf("freeze%0d_count", k), count, 5'd4);
    end
    ena = 1'b1;
    step();
    chk("unfreeze_addr", out_addr, 4'h1);
    chk("unfreeze_data", out_data, 8'h22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
